// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, using a single borrow flip-flop.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             dbit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  function automatic logic sub_bit(input logic ai, input logic bi, input logic br);
    return ai ^ bi ^ br;
  endfunction

  function automatic logic sub_borrow(input logic ai, input logic bi, input logic br);
    return (~ai & bi) | (~(ai ^ bi) & br);
  endfunction

  // One full-subtractor slice on the current operand LSBs; result fills from the MSB end.
  always_comb begin
    dbit_d = sub_bit(a_q[0], b_q[0], br_q);
    br_d   = sub_borrow(a_q[0], b_q[0], br_q);
    res_d  = {dbit_d, res_q[WIDTH-1:1]};
    a_d    = {1'b0, a_q[WIDTH-1:1]};
    b_d    = {1'b0, b_q[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  logic ovf_d;

  // The final slice produces the result MSB, so overflow is known on the completing edge.
  always_comb begin
    ovf_d = (a_msb_q ^ b_msb_q) & (dbit_d ^ a_msb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q != RUN && start) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state_q == RUN && cnt_q == LAST) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          // Published outputs change only here, so partial results never leak out.
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes reference results, a monitor pops on done.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_run = 0;
  logic [W-1:0] prev_diff = '0;
  logic rst_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int av, input int bv);
    exp_t e;
    int sa, sb_v, sd;
    e.d  = W'((av - bv) & ((1 << W) - 1));
    e.bo = (av < bv);
    sa   = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb_v = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    sd   = sa - sb_v;
    e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return e;
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge rst) rst_seen = 1'b1;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    check("busy_done_exclusive", int'(busy & done), 0);
    if (diff !== prev_diff && !done && !rst_seen)
      check("diff_stable", int'(diff), int'(prev_diff));
    prev_diff = diff;
    rst_seen  = 1'b0;
    if (done) begin
      done_cyc.push_back(cyc);
      check("busy_cycles", busy_run, W);
      busy_run = 0;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("diff", int'(diff), int'(e.d));
        check("bout", int'(bout), int'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf), int'(e.ov));
`endif
      end
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_op(input int av, input int bv);
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    sb.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", int'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int order[256];
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(9, 3);
    drain();
    run_op(3, 9);
    run_op(0, 1);
    run_op(15, 15);
    drain();
`ifdef SERIAL_SUB_OVF_EN
    run_op(7, 8);
    run_op(4, 2);
    drain();
`endif

    // Start held high: accepted in IDLE, ignored while busy, re-accepted in the done cycle.
    done_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    a = W'(9);
    b = W'(3);
    sb.push_back(model(9, 3));
    sb.push_back(model(9, 3));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_cyc.size() >= 2) break;
    end
    start = 1'b0;
    check("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() >= 2)
      check("b2b_spacing", done_cyc[1] - done_cyc[0], W + 1);
    drain();

    // Abort mid-run: asynchronous reset during the second busy cycle.
    run_op(13, 2);
    drain();
    @(negedge clk);
    start = 1'b1;
    a = W'(12);
    b = W'(5);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(12, 5);
    drain();

    // Sweep every operand pair in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      run_op(order[i] >> 4, order[i] & 15);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    drain();
    check("scoreboard_empty", int'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `diff = a - b` one bit per clock, LSB first. It uses a single borrow flip-flop, so it is the inverse-operation counterpart of the ripple full-adder chain in the arithmetic library. It sits beside the adders as a small-area datapath option and accepts operands through a start/busy/done handshake.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal values are ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; samples `a`/`b` when accepted.
- `a`  in  WIDTH: minuend, unsigned or two's complement.
- `b`  in  WIDTH: subtrahend.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse; result registers updated on the same edge.
- `diff`  out  WIDTH: result `(a - b) mod 2^WIDTH`.
- `bout`  out  1: unsigned borrow out; 1 iff `a < b` as unsigned values.
- `ovf`  out  1: signed overflow (present only with `SERIAL_SUB_OVF_EN`).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0. Internal shift registers, borrow FF and bit counter are all cleared.
- IDLE/DONE with `start`=1: load the `a` and `b` shift registers, clear the borrow, set count=0, go to RUN.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle, with `ai`/`bi` the current LSBs and `br` the borrow FF:
  - d = ai ^ bi ^ br
  - br' = (~ai & bi) | (~(ai ^ bi) & br)
  - Shift d into the MSB of the working result; shift the operands right; increment count.
- RUN, when count = WIDTH-1: process the last bit, then copy the working result to `diff` and br' to `bout`, and go to DONE.
- `start` in RUN is ignored; operands are not resampled.
- `diff`/`bout`/`ovf` hold their last result until the next completion or reset. They never show partial values.
- Reset mid-RUN aborts: all outputs return to reset values and the state returns to IDLE. No `done` is generated for the aborted operation.

## Timing
- Accepting edge E0 (`start`=1 in IDLE or DONE).
- `busy`=1 from after E0 through edge E0+WIDTH, i.e. exactly WIDTH cycles.
- After E0+WIDTH: `done`=1 and `busy`=0 for exactly one cycle, and the new `diff`/`bout`/`ovf` are visible.
- Latency: WIDTH cycles from the accepting edge to the result.
- Back-to-back: `start`=1 during the `done` cycle is accepted. Throughput is then one result per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Configuration
- `SERIAL_SUB_OVF_EN` defined: the `ovf` port exists. At completion, `ovf` = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb), using the latched `a`/`b` MSBs. Its reset value is 0, and it holds with `diff`.
- `SERIAL_SUB_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=4, a=9, b=3, pulse `start` → `busy` high 4 cycles, then `done` pulse with `diff`=6, `bout`=0.
- a=3, b=9 → `diff`=0xA, `bout`=1. Also a=0, b=1 → `diff`=0xF, `bout`=1, and a=15, b=15 → `diff`=0, `bout`=0.
- Run a=9, b=3 and hold `start`=1 throughout → the second start is ignored during `busy` and accepted in the `done` cycle. Results arrive 5 cycles apart and `diff`=6 both times.
- Start a=12, b=5, assert `rst` at the 2nd busy cycle → all outputs 0 immediately (asynchronous), no `done`. A following run of a=12, b=5 yields `diff`=7.
- With `SERIAL_SUB_OVF_EN`: a=7, b=8 (−8) → `diff`=0xF, `ovf`=1. a=4, b=2 → `diff`=2, `ovf`=0.
- Random sweep over all 256 WIDTH=4 operand pairs → `diff`/`bout` match a reference model. `diff` never changes except on a `done` edge or reset.
